// File: rtl/dice_pkg.sv
// rtl/dice_pkg.sv - shared die type, face limits, FSM state encoding
package dice_pkg;

  typedef logic [2:0] die_t;

  localparam die_t DIE_MIN = 3'd1;
  localparam die_t DIE_MAX = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ROLL    = 2'd1,
    ST_PRESENT = 2'd2
  } state_t;

  function automatic die_t die_next(input die_t d);
    return (d == DIE_MAX) ? DIE_MIN : die_t'(d + 3'd1);
  endfunction

endpackage

// File: rtl/roll_debounce.sv
// rtl/roll_debounce.sv - 2-flop synchronizer plus level debouncer for the roll button
module roll_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_db
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          r_sync1;
  logic          r_sync2;
  logic          r_db;
  logic [CW-1:0] r_cnt;

  // r_cnt counts consecutive synchronized samples that disagree with r_db
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_db    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        r_db  <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_db = r_db;

endmodule

// File: rtl/dice_roller.sv
// rtl/dice_roller.sv - two-die roller: debounced button, free-running faces, valid/ready result
module dice_roller
  import dice_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MIN_ROLL_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       roll_btn,
  input  logic       roll_ready,
  output logic [2:0] die1,
  output logic [2:0] die2,
  output logic [3:0] sum,
  output logic       roll_valid,
  output logic       rolling,
  output logic [7:0] roll_count
);

  localparam int TW = $clog2(MIN_ROLL_CYCLES) + 1;
  localparam logic [TW-1:0] TIMER_MAX = '1;

  logic          w_db;
  logic          r_db_prev;
  logic          w_db_rise;
  die_t          r_c1;
  die_t          r_c2;
  die_t          r_cap1;
  die_t          r_cap2;
  logic [TW-1:0] r_timer;
  logic          w_timer_done;
  logic [7:0]    r_count;
  state_t        r_state;
  state_t        w_state_next;
  logic          w_start;
  logic          w_capture;
  logic          w_handshake;

  roll_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk  (clk),
    .rst  (rst),
    .i_btn(roll_btn),
    .o_db (w_db)
  );

  assign w_db_rise = w_db & ~r_db_prev;

  // Timer holds the number of ROLL cycles already completed, so this cycle is the last required one
  assign w_timer_done = (r_timer >= TW'(MIN_ROLL_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_capture    = 1'b0;
    w_handshake  = 1'b0;
    rolling      = 1'b0;
    roll_valid   = 1'b0;
    die1         = r_cap1;
    die2         = r_cap2;
    unique case (r_state)
      ST_IDLE: begin
        if (w_db_rise) begin
          w_start      = 1'b1;
          w_state_next = ST_ROLL;
        end
      end
      ST_ROLL: begin
        rolling = 1'b1;
        die1    = r_c1;
        die2    = r_c2;
        if (!w_db && w_timer_done) begin
          w_capture    = 1'b1;
          w_state_next = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        roll_valid = 1'b1;
        if (roll_ready) begin
          w_handshake  = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Faces tumble in every state; the press timing is the only source of randomness
  always_ff @(posedge clk) begin
    if (rst) begin
      r_c1      <= DIE_MIN;
      r_c2      <= DIE_MIN;
      r_db_prev <= 1'b0;
      r_timer   <= '0;
      r_cap1    <= '0;
      r_cap2    <= '0;
      r_count   <= '0;
    end else begin
      r_c1      <= die_next(r_c1);
      if (r_c1 == DIE_MAX) begin
        r_c2 <= die_next(r_c2);
      end
      r_db_prev <= w_db;
      if (w_start) begin
        r_timer <= '0;
      end else if (r_state == ST_ROLL && r_timer != TIMER_MAX) begin
        r_timer <= r_timer + 1'b1;
      end
      if (w_capture) begin
        r_cap1 <= r_c1;
        r_cap2 <= r_c2;
      end
      if (w_handshake) begin
        r_count <= r_count + 8'd1;
      end
    end
  end

  assign sum        = {1'b0, die1} + {1'b0, die2};
  assign roll_count = r_count;

endmodule

// File: tb/tb_dice_roller.sv
// tb/tb_dice_roller.sv - directed self-checking bench for dice_roller
module tb_dice_roller;

  logic       clk;
  logic       rst;
  logic       roll_btn;
  logic       roll_ready;
  logic [2:0] die1;
  logic [2:0] die2;
  logic [3:0] sum;
  logic       roll_valid;
  logic       rolling;
  logic [7:0] roll_count;

  int n_checks = 0;
  int n_fails  = 0;

  int         m_cyc = 0;
  logic [2:0] m_c1;
  logic [2:0] m_c2;

  dice_roller #(
    .DEBOUNCE_CYCLES(4),
    .MIN_ROLL_CYCLES(16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .roll_btn  (roll_btn),
    .roll_ready(roll_ready),
    .die1      (die1),
    .die2      (die2),
    .sum       (sum),
    .roll_valid(roll_valid),
    .rolling   (rolling),
    .roll_count(roll_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference faces: cycles since the last reset edge, c1 fastest, c2 stepping every sixth cycle
  always @(posedge clk) begin
    if (rst) m_cyc <= 0;
    else     m_cyc <= m_cyc + 1;
  end
  assign m_c1 = 3'(m_cyc % 6 + 1);
  assign m_c2 = 3'((m_cyc / 6) % 6 + 1);

  task automatic test_reset();
    rst = 1'b1; roll_btn = 1'b0; roll_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({die1, die2, sum, roll_valid, rolling, roll_count} !== 25'd0) begin
      n_fails++;
      $display("FAIL reset_outputs die1=%0d die2=%0d sum=%0d valid=%0b rolling=%0b count=%0d expected all 0",
               die1, die2, sum, roll_valid, rolling, roll_count);
    end
    rst = 1'b0;
    n_checks++;
    if (dut.r_c1 !== 3'd1) begin
      n_fails++;
      $display("FAIL reset_c1 c1=%0d expected 1", dut.r_c1);
    end
    @(negedge clk);
    n_checks++;
    if (dut.r_c1 !== 3'd2) begin
      n_fails++;
      $display("FAIL c1_advance c1=%0d expected 2", dut.r_c1);
    end
  endtask

  task automatic test_glitch();
    bit bad = 0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      if (rolling !== 1'b0 || roll_valid !== 1'b0) bad = 1;
      roll_btn = (i < 2);
      @(negedge clk);
    end
    n_checks++;
    if (bad) begin
      n_fails++;
      $display("FAIL glitch_ignored rolling/valid went high, expected both to stay 0");
    end
  endtask

  task automatic test_rst_mid_roll();
    logic was_rolling = 1'b0;
    bit   bad = 0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      if (i == 9) was_rolling = rolling;
      roll_btn = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (was_rolling !== 1'b1) begin
      n_fails++;
      $display("FAIL pre_reset_rolling rolling=%0b expected 1", was_rolling);
    end
    rst = 1'b1; roll_btn = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (rolling !== 1'b0 || roll_valid !== 1'b0 || die1 !== 3'd0 || die2 !== 3'd0 || sum !== 4'd0) begin
      n_fails++;
      $display("FAIL rst_mid_roll rolling=%0b valid=%0b die1=%0d die2=%0d sum=%0d expected 0 0 0 0 0",
               rolling, roll_valid, die1, die2, sum);
    end
    for (int i = 0; i < 15; i++) begin
      if (rolling !== 1'b0 || roll_valid !== 1'b0) bad = 1;
      @(negedge clk);
    end
    n_checks++;
    if (bad || roll_count !== 8'd0) begin
      n_fails++;
      $display("FAIL rst_mid_roll_quiet count=%0d activity=%0b expected count 0 and no activity", roll_count, bad);
    end
  endtask

  task automatic test_normal_roll();
    int         first_roll = -1;
    int         n_roll = 0;
    int         first_valid = -1;
    bit         bad = 0;
    logic [2:0] e1 = 3'd0;
    logic [2:0] e2 = 3'd0;
    roll_ready = 1'b0; roll_btn = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++;
    if (die1 !== 3'd0 || die2 !== 3'd0 || sum !== 4'd0) begin
      n_fails++;
      $display("FAIL idle_no_roll die1=%0d die2=%0d sum=%0d expected 0 0 0", die1, die2, sum);
    end
    for (int i = 0; i < 200 && first_valid < 0; i++) begin
      if (rolling === 1'b1) begin
        if (first_roll < 0) first_roll = i;
        n_roll++;
        if (die1 !== m_c1 || die2 !== m_c2 || sum !== ({1'b0, m_c1} + {1'b0, m_c2})) bad = 1;
        e1 = m_c1; e2 = m_c2;
      end
      if (roll_valid === 1'b1) first_valid = i;
      roll_btn = (i < 40);
      if (first_valid < 0) @(negedge clk);
    end
    n_checks++;
    if (first_roll !== 7) begin
      n_fails++;
      $display("FAIL normal_roll_start rolling at cycle %0d expected 7", first_roll);
    end
    n_checks++;
    if (n_roll !== 40) begin
      n_fails++;
      $display("FAIL normal_roll_len rolling cycles=%0d expected 40", n_roll);
    end
    n_checks++;
    if (first_valid !== 47) begin
      n_fails++;
      $display("FAIL normal_valid_latency valid at cycle %0d expected 47", first_valid);
    end
    n_checks++;
    if (bad) begin
      n_fails++;
      $display("FAIL live_dice dice or sum differed from model faces while rolling");
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (roll_valid !== 1'b1 || rolling !== 1'b0 || die1 !== e1 || die2 !== e2 ||
          sum !== ({1'b0, e1} + {1'b0, e2})) bad = 1;
      @(negedge clk);
    end
    n_checks++;
    if (bad) begin
      n_fails++;
      $display("FAIL present_hold die1=%0d die2=%0d sum=%0d valid=%0b expected %0d %0d %0d 1",
               die1, die2, sum, roll_valid, e1, e2, e1 + e2);
    end
    roll_ready = 1'b1;
    @(negedge clk);
    roll_ready = 1'b0;
    n_checks++;
    if (roll_valid !== 1'b0 || roll_count !== 8'd1 || die1 !== e1 || die2 !== e2) begin
      n_fails++;
      $display("FAIL normal_handshake valid=%0b count=%0d die1=%0d die2=%0d expected 0 1 %0d %0d",
               roll_valid, roll_count, die1, die2, e1, e2);
    end
  endtask

  task automatic test_early_release();
    int first_roll = -1;
    int n_roll = 0;
    int first_valid = -1;
    roll_ready = 1'b0; roll_btn = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 100 && first_valid < 0; i++) begin
      if (rolling === 1'b1) begin
        if (first_roll < 0) first_roll = i;
        n_roll++;
      end
      if (roll_valid === 1'b1) first_valid = i;
      roll_btn = (i < 5);
      if (first_valid < 0) @(negedge clk);
    end
    n_checks++;
    if (n_roll !== 16 || first_roll !== 7) begin
      n_fails++;
      $display("FAIL early_roll_len rolling cycles=%0d start=%0d expected 16 starting at 7", n_roll, first_roll);
    end
    n_checks++;
    if (first_valid !== 23) begin
      n_fails++;
      $display("FAIL early_valid_latency valid at cycle %0d expected 23", first_valid);
    end
    roll_ready = 1'b1;
    @(negedge clk);
    roll_ready = 1'b0;
    n_checks++;
    if (roll_count !== 8'd2 || roll_valid !== 1'b0) begin
      n_fails++;
      $display("FAIL early_handshake count=%0d valid=%0b expected 2 0", roll_count, roll_valid);
    end
  endtask

  task automatic test_back_to_back();
    int         n_roll = 0;
    int         n_valid = 0;
    int         first_valid = -1;
    logic [2:0] e1 = 3'd0;
    logic [2:0] e2 = 3'd0;
    bit         bad = 0;
    roll_ready = 1'b1; roll_btn = 1'b0;
    repeat (10) @(negedge clk);
    // Second press is timed so its debounced edge lands in the single PRESENT cycle
    for (int i = 0; i < 60; i++) begin
      if (rolling === 1'b1) begin
        n_roll++;
        e1 = m_c1; e2 = m_c2;
      end
      if (roll_valid === 1'b1) begin
        n_valid++;
        if (first_valid < 0) first_valid = i;
        if (die1 !== e1 || die2 !== e2 || sum !== ({1'b0, e1} + {1'b0, e2})) bad = 1;
      end
      roll_btn = (i < 5) || (i >= 17 && i < 27);
      @(negedge clk);
    end
    roll_ready = 1'b0;
    n_checks++;
    if (n_valid !== 1 || first_valid !== 23) begin
      n_fails++;
      $display("FAIL ready_high_pulse valid cycles=%0d at %0d expected 1 at 23", n_valid, first_valid);
    end
    n_checks++;
    if (n_roll !== 16) begin
      n_fails++;
      $display("FAIL present_press_ignored rolling cycles=%0d expected 16", n_roll);
    end
    n_checks++;
    if (bad) begin
      n_fails++;
      $display("FAIL ready_high_capture presented dice did not match model faces at capture");
    end
    n_checks++;
    if (roll_count !== 8'd3) begin
      n_fails++;
      $display("FAIL ready_high_count count=%0d expected 3", roll_count);
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_rst_mid_roll();
    test_normal_roll();
    test_early_release();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
